updown_counter_n: RTL and testbench

//  Parametrised loadable up/down counter, successor to the fixed 3-bit load/increment counter.

---
 rtl/updown_counter_n_if.sv | 41 ++++
 rtl/updown_counter_n.sv | 91 +++++++++
 tb/tb_updown_counter_n.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/updown_counter_n_if.sv
// rtl/updown_counter_n_if.sv - control/status bundle for updown_counter_n (optional CNT_MATCH_EN ports)
interface updown_counter_n_if #(
    parameter int WIDTH = 8
);
    logic             ld_i;
    logic             inc_i;
    logic             dec_i;
    logic             clr_flags_i;
    logic [WIDTH-1:0] data_in_i;
    logic [WIDTH-1:0] data_out_o;
    logic             at_max_o;
    logic             at_min_o;
    logic             ovf_o;
    logic             udf_o;
    logic             ld_err_o;
`ifdef CNT_MATCH_EN
    logic             cmp_ld_i;
    logic [WIDTH-1:0] cmp_in_i;
    logic             match_o;
`endif

`ifdef CNT_MATCH_EN
    modport master (
        output ld_i, inc_i, dec_i, clr_flags_i, data_in_i, cmp_ld_i, cmp_in_i,
        input  data_out_o, at_max_o, at_min_o, ovf_o, udf_o, ld_err_o, match_o
    );
    modport slave (
        input  ld_i, inc_i, dec_i, clr_flags_i, data_in_i, cmp_ld_i, cmp_in_i,
        output data_out_o, at_max_o, at_min_o, ovf_o, udf_o, ld_err_o, match_o
    );
`else
    modport master (
        output ld_i, inc_i, dec_i, clr_flags_i, data_in_i,
        input  data_out_o, at_max_o, at_min_o, ovf_o, udf_o, ld_err_o
    );
    modport slave (
        input  ld_i, inc_i, dec_i, clr_flags_i, data_in_i,
        output data_out_o, at_max_o, at_min_o, ovf_o, udf_o, ld_err_o
    );
`endif
endinterface

// File: rtl/updown_counter_n.sv
// rtl/updown_counter_n.sv - loadable up/down counter, wrap/saturate, sticky flags; optional CNT_MATCH_EN compare
module updown_counter_n #(
    parameter int             WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter bit             SATURATE = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    updown_counter_n_if.slave  bus
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             ld_err_q, ld_err_d;

    // Next count and flags: ld beats inc/dec; inc and dec together cancel out
    always_comb begin
        data_d   = data_q;
        ovf_d    = ovf_q & ~bus.clr_flags_i;
        udf_d    = udf_q & ~bus.clr_flags_i;
        ld_err_d = 1'b0;
        if (bus.ld_i) begin
            if (bus.data_in_i > MAX_VAL) begin
                data_d   = MAX_VAL;
                ld_err_d = 1'b1;
            end else begin
                data_d = bus.data_in_i;
            end
        end else if (bus.inc_i && !bus.dec_i) begin
            if (data_q == MAX_VAL) begin
                ovf_d = 1'b1;
                if (!SATURATE) data_d = '0;
            end else begin
                data_d = data_q + 1'b1;
            end
        end else if (bus.dec_i && !bus.inc_i) begin
            if (data_q == '0) begin
                udf_d = 1'b1;
                if (!SATURATE) data_d = MAX_VAL;
            end else begin
                data_d = data_q - 1'b1;
            end
        end
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            ld_err_q <= ld_err_d;
        end
    end

    assign bus.data_out_o = data_q;
    assign bus.at_max_o   = (data_q == MAX_VAL);
    assign bus.at_min_o   = (data_q == '0);
    assign bus.ovf_o      = ovf_q;
    assign bus.udf_o      = udf_q;
    assign bus.ld_err_o   = ld_err_q;

`ifdef CNT_MATCH_EN
    logic [WIDTH-1:0] cmp_q, cmp_d;
    logic             match_q, match_d;

    // Match fires only when the count moves onto the compare value, never while it sits there
    always_comb begin
        cmp_d   = bus.cmp_ld_i ? bus.cmp_in_i : cmp_q;
        match_d = (data_d != data_q) && (data_d == cmp_q);
    end

    // Compare register and registered match pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_q   <= MAX_VAL;
            match_q <= 1'b0;
        end else begin
            cmp_q   <= cmp_d;
            match_q <= match_d;
        end
    end

    assign bus.match_o = match_q;
`endif
endmodule

// File: tb/tb_updown_counter_n.sv
// tb/tb_updown_counter_n.sv - directed self-checking bench for updown_counter_n (three configurations)
module tb_updown_counter_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    updown_counter_n_if #(.WIDTH(8)) if8 ();
    updown_counter_n_if #(.WIDTH(4)) ifw ();
    updown_counter_n_if #(.WIDTH(4)) ifs ();

    updown_counter_n #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(if8));
    updown_counter_n #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) uw (.clk(clk), .rst(rst), .bus(ifw));
    updown_counter_n #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) us (.clk(clk), .rst(rst), .bus(ifs));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if8.ld_i = 0; if8.inc_i = 0; if8.dec_i = 0; if8.clr_flags_i = 0; if8.data_in_i = '0;
        ifw.ld_i = 0; ifw.inc_i = 0; ifw.dec_i = 0; ifw.clr_flags_i = 0; ifw.data_in_i = '0;
        ifs.ld_i = 0; ifs.inc_i = 0; ifs.dec_i = 0; ifs.clr_flags_i = 0; ifs.data_in_i = '0;
`ifdef CNT_MATCH_EN
        if8.cmp_ld_i = 0; if8.cmp_in_i = '0;
        ifw.cmp_ld_i = 0; ifw.cmp_in_i = '0;
        ifs.cmp_ld_i = 0; ifs.cmp_in_i = '0;
`endif
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1; if8.ld_i = 1; if8.inc_i = 1; if8.data_in_i = 8'h55;
        step();
        n_vec++; if (if8.data_out_o !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", if8.data_out_o); end
        n_vec++; if ({if8.ovf_o, if8.udf_o, if8.ld_err_o} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {if8.ovf_o, if8.udf_o, if8.ld_err_o}); end
        n_vec++; if (if8.at_min_o !== 1'b1) begin n_fail++; $display("FAIL reset_at_min: got %b expected 1", if8.at_min_o); end
        n_vec++; if (ifw.data_out_o !== 4'd0) begin n_fail++; $display("FAIL reset_data_w: got %0d expected 0", ifw.data_out_o); end
        rst = 0; if8.data_in_i = 8'h10;
        step();
        n_vec++; if (if8.data_out_o !== 8'h10) begin n_fail++; $display("FAIL ld_over_inc: got %0h expected 10", if8.data_out_o); end
        idle_all();
        if8.ld_i = 1; if8.data_in_i = 8'hFF; step();
        if8.ld_i = 0; if8.inc_i = 1; step();
        n_vec++; if ({if8.data_out_o, if8.ovf_o} !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL wrap8: got %0h/%b expected 0/1", if8.data_out_o, if8.ovf_o); end
        idle_all();
    endtask

    task automatic test_wrap();
        idle_all();
        ifw.ld_i = 1; ifw.data_in_i = 4'd8; step();
        n_vec++; if (ifw.data_out_o !== 4'd8) begin n_fail++; $display("FAIL wrap_load8: got %0d expected 8", ifw.data_out_o); end
        ifw.ld_i = 0; ifw.inc_i = 1; step();
        n_vec++; if ({ifw.data_out_o, ifw.at_max_o, ifw.ovf_o} !== {4'd9, 1'b1, 1'b0}) begin n_fail++; $display("FAIL wrap_to9: got %0d/%b/%b expected 9/1/0", ifw.data_out_o, ifw.at_max_o, ifw.ovf_o); end
        step();
        n_vec++; if ({ifw.data_out_o, ifw.at_min_o, ifw.ovf_o} !== {4'd0, 1'b1, 1'b1}) begin n_fail++; $display("FAIL wrap_to0: got %0d/%b/%b expected 0/1/1", ifw.data_out_o, ifw.at_min_o, ifw.ovf_o); end
        ifw.inc_i = 0; ifw.dec_i = 1; step();
        n_vec++; if ({ifw.data_out_o, ifw.udf_o} !== {4'd9, 1'b1}) begin n_fail++; $display("FAIL wrap_dec0: got %0d/%b expected 9/1", ifw.data_out_o, ifw.udf_o); end
        step();
        n_vec++; if (ifw.data_out_o !== 4'd8) begin n_fail++; $display("FAIL dec9: got %0d expected 8", ifw.data_out_o); end
        idle_all();
    endtask

    task automatic test_saturate();
        idle_all();
        ifs.ld_i = 1; ifs.data_in_i = 4'd9; step();
        ifs.ld_i = 0; ifs.inc_i = 1; step(); step(); step();
        n_vec++; if ({ifs.data_out_o, ifs.ovf_o, ifs.at_max_o} !== {4'd9, 1'b1, 1'b1}) begin n_fail++; $display("FAIL sat_max: got %0d/%b/%b expected 9/1/1", ifs.data_out_o, ifs.ovf_o, ifs.at_max_o); end
        ifs.inc_i = 0; ifs.ld_i = 1; ifs.data_in_i = 4'd0; step();
        ifs.ld_i = 0; ifs.dec_i = 1; step();
        n_vec++; if ({ifs.data_out_o, ifs.udf_o} !== {4'd0, 1'b1}) begin n_fail++; $display("FAIL sat_min: got %0d/%b expected 0/1", ifs.data_out_o, ifs.udf_o); end
        ifs.dec_i = 0; ifs.ld_i = 1; ifs.data_in_i = 4'd5; step();
        ifs.ld_i = 0; ifs.inc_i = 1; ifs.dec_i = 1; step();
        n_vec++; if (ifs.data_out_o !== 4'd5) begin n_fail++; $display("FAIL sat_incdec: got %0d expected 5", ifs.data_out_o); end
        idle_all();
    endtask

    task automatic test_load_clamp();
        idle_all();
        ifw.ld_i = 1; ifw.data_in_i = 4'd12; step();
        n_vec++; if ({ifw.data_out_o, ifw.ld_err_o} !== {4'd9, 1'b1}) begin n_fail++; $display("FAIL clamp: got %0d/%b expected 9/1", ifw.data_out_o, ifw.ld_err_o); end
        n_vec++; if ({ifw.ovf_o, ifw.udf_o} !== 2'b11) begin n_fail++; $display("FAIL clamp_flags_kept: got %b expected 11", {ifw.ovf_o, ifw.udf_o}); end
        ifw.ld_i = 0; step();
        n_vec++; if ({ifw.data_out_o, ifw.ld_err_o} !== {4'd9, 1'b0}) begin n_fail++; $display("FAIL clamp_pulse: got %0d/%b expected 9/0", ifw.data_out_o, ifw.ld_err_o); end
        ifw.ld_i = 1; ifw.data_in_i = 4'd9; step();
        n_vec++; if ({ifw.data_out_o, ifw.ld_err_o} !== {4'd9, 1'b0}) begin n_fail++; $display("FAIL load_max_ok: got %0d/%b expected 9/0", ifw.data_out_o, ifw.ld_err_o); end
        idle_all();
    endtask

    task automatic test_flags();
        idle_all();
        ifw.clr_flags_i = 1; step();
        n_vec++; if ({ifw.ovf_o, ifw.udf_o} !== 2'b00) begin n_fail++; $display("FAIL clr_flags: got %b expected 00", {ifw.ovf_o, ifw.udf_o}); end
        ifw.clr_flags_i = 0; ifw.ld_i = 1; ifw.data_in_i = 4'd9; step();
        ifw.ld_i = 0; ifw.inc_i = 1; ifw.clr_flags_i = 1; step();
        n_vec++; if ({ifw.data_out_o, ifw.ovf_o} !== {4'd0, 1'b1}) begin n_fail++; $display("FAIL clr_vs_ovf: got %0d/%b expected 0/1", ifw.data_out_o, ifw.ovf_o); end
        ifw.inc_i = 0; ifw.clr_flags_i = 0; ifw.ld_i = 1; ifw.data_in_i = 4'd5; step();
        ifw.ld_i = 0; ifw.inc_i = 1; rst = 1; step();
        n_vec++; if ({ifw.data_out_o, ifw.ovf_o} !== {4'd0, 1'b0}) begin n_fail++; $display("FAIL rst_midcount: got %0d/%b expected 0/0", ifw.data_out_o, ifw.ovf_o); end
        rst = 0; step();
        n_vec++; if (ifw.data_out_o !== 4'd1) begin n_fail++; $display("FAIL resume: got %0d expected 1", ifw.data_out_o); end
        idle_all();
    endtask

`ifdef CNT_MATCH_EN
    task automatic test_match();
        logic [3:0] exp_d [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd3, 4'd3};
        logic       exp_m [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        idle_all();
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 8; i++) begin
            idle_all();
            case (i)
                0: begin ifw.cmp_ld_i = 1; ifw.cmp_in_i = 4'd3; end
                1, 2, 3, 5: ifw.inc_i = 1;
                6: begin ifw.ld_i = 1; ifw.data_in_i = 4'd3; end
                default: ;
            endcase
            step();
            n_vec++; if ({ifw.data_out_o, ifw.match_o} !== {exp_d[i], exp_m[i]}) begin n_fail++; $display("FAIL match_%0d: got %0d/%b expected %0d/%b", i, ifw.data_out_o, ifw.match_o, exp_d[i], exp_m[i]); end
        end
        idle_all();
    endtask
`endif

    initial begin
        idle_all();
        test_reset();
        test_wrap();
        test_saturate();
        test_load_clamp();
        test_flags();
`ifdef CNT_MATCH_EN
        test_match();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
